// File: rtl/io_periph.sv
// io_periph: memory-mapped output port, synchronized input port with edge interrupts, and a down-counting timer.
// Define IO_PERIPH_TIMER_EN to build the RELOAD/COUNT/CTRL timer; without it offsets 2-4 read 0.
module io_periph #(
  parameter logic [15:0] BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Direcciones,
  input  logic        cpu_oe,
  inout  wire  [15:0] Datos,
  input  logic [15:0] pin_in,
  output logic [15:0] pin_out,
  output logic [7:0]  intr
);
  logic        hit, wr, rd;
  logic [2:0]  off;
  logic [15:0] port_q, port_d, s1_q, s2_q, rdata;
  logic [6:0]  prev_q;
  logic [7:0]  pend_q, pend_d, mask_q, mask_d, set;
  logic        tmr_set;
  assign hit = Direcciones[15:3] == BASE[15:3];
  assign off = Direcciones[2:0];
  assign wr  = hit && cpu_oe;
  assign rd  = hit && !cpu_oe;
`ifdef IO_PERIPH_TIMER_EN
  logic [15:0] reload_q, reload_d, count_q, count_d;
  logic [1:0]  ctrl_q, ctrl_d;
  // A RELOAD write preempts decrement/reload; a CTRL write preempts one-shot disable.
  always_comb begin
    tmr_set  = ctrl_q[0] && count_q == '0;
    reload_d = (wr && off == 3'd2) ? Datos : reload_q;
    count_d  = (wr && off == 3'd2) ? Datos :
               !ctrl_q[0]          ? count_q :
               !tmr_set            ? count_q - 16'd1 :
               ctrl_q[1]           ? reload_q : count_q;
    ctrl_d   = (wr && off == 3'd4) ? Datos[1:0] :
               (tmr_set && !ctrl_q[1]) ? 2'b00 : ctrl_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      reload_q <= '0;
      count_q  <= '0;
      ctrl_q   <= '0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      ctrl_q   <= ctrl_d;
    end
`else
  assign tmr_set = 1'b0;
`endif
  // Set sources win over a simultaneous write-1-to-clear.
  always_comb begin
    set    = {s2_q[6:0] & ~prev_q, tmr_set};
    pend_d = (pend_q & ~((wr && off == 3'd5) ? Datos[7:0] : 8'h00)) | set;
    mask_d = (wr && off == 3'd6) ? Datos[7:0] : mask_q;
    port_d = (wr && off == 3'd0) ? Datos : port_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      port_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      port_q <= port_d;
      s1_q   <= pin_in;
      s2_q   <= s1_q;
      prev_q <= s2_q[6:0];
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = port_q;
      3'd1:    rdata = s2_q;
`ifdef IO_PERIPH_TIMER_EN
      3'd2:    rdata = reload_q;
      3'd3:    rdata = count_q;
      3'd4:    rdata = {14'h0, ctrl_q};
`endif
      3'd5:    rdata = {8'h00, pend_q};
      3'd6:    rdata = {8'h00, mask_q};
      default: rdata = '0;
    endcase
  end
  assign Datos   = (rd && reset) ? rdata : 'z;
  assign pin_out = port_q;
  assign intr    = pend_q & mask_q;
endmodule

// File: tb/tb_io_periph.sv
// tb_io_periph: table-driven register checks plus hand sequences for sync, edge interrupts, timer and reset.
module tb_io_periph;
  localparam logic [15:0] BASE = 16'hFF00;
  logic        clk = 1'b0, reset = 1'b0, cpu_oe = 1'b0, drv_en = 1'b0;
  logic [15:0] addr = '0, drv = '0, pin_in = '0;
  wire  [15:0] datos;
  logic [15:0] pin_out;
  logic [7:0]  intr;
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  typedef struct {
    logic [2:0]  off;
    logic [15:0] wdata;
    logic [15:0] rexp;
    logic [15:0] pout;
    string       name;
  } vec_t;
  vec_t vecs[$];

  assign datos = drv_en ? drv : 'z;
  always #5 clk = ~clk;

  io_periph #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .Direcciones(addr), .cpu_oe(cpu_oe),
    .Datos(datos), .pin_in(pin_in), .pin_out(pin_out), .intr(intr)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d);
    addr = BASE | 16'(off); cpu_oe = 1'b1; drv = d; drv_en = 1'b1;
    @(posedge clk);
    #1;
    cpu_oe = 1'b0; drv_en = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd(input logic [2:0] off, input logic [15:0] exp, input string name);
    addr = BASE | 16'(off); cpu_oe = 1'b0; drv_en = 1'b0;
    exp_q.push_back(exp);
    #1;
    chk(name, datos, exp_q.pop_front());
    addr = 16'h0000;
  endtask

  function automatic void add(input logic [2:0] o, input logic [15:0] w, input logic [15:0] r,
                              input logic [15:0] p, input string n);
    vec_t v;
    v.off = o; v.wdata = w; v.rexp = r; v.pout = p; v.name = n;
    vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add(3'd0, 16'hA5C3, 16'hA5C3, 16'hA5C3, "port_out");
    add(3'd6, 16'h12FF, 16'h00FF, 16'hA5C3, "mask_hi");
    add(3'd6, 16'h0000, 16'h0000, 16'hA5C3, "mask_zero");
    add(3'd7, 16'hFFFF, 16'h0000, 16'hA5C3, "off7");
    add(3'd1, 16'h1234, 16'h0000, 16'hA5C3, "port_in_ro");
    add(3'd5, 16'h00FF, 16'h0000, 16'hA5C3, "pend_w1c_idle");
    add(3'd0, 16'h5A3C, 16'h5A3C, 16'h5A3C, "port_out2");
`ifdef IO_PERIPH_TIMER_EN
    add(3'd2, 16'h1234, 16'h1234, 16'h5A3C, "reload");
    add(3'd3, 16'hFFFF, 16'h1234, 16'h5A3C, "count_ro");
    add(3'd4, 16'hFFFE, 16'h0002, 16'h5A3C, "ctrl_bits");
    add(3'd4, 16'h0000, 16'h0000, 16'h5A3C, "ctrl_zero");
    add(3'd2, 16'h0000, 16'h0000, 16'h5A3C, "reload_zero");
`else
    add(3'd2, 16'h1234, 16'h0000, 16'h5A3C, "reload_off");
    add(3'd3, 16'hFFFF, 16'h0000, 16'h5A3C, "count_off");
    add(3'd4, 16'hFFFF, 16'h0000, 16'h5A3C, "ctrl_off");
`endif
    add(3'd0, 16'hA5C3, 16'hA5C3, 16'hA5C3, "port_out3");

    // reset with all pins high, then release
    pin_in = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk("rst_pin_out", pin_out, 16'h0000);
    chk("rst_intr", 16'(intr), 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    tick(); rd(3'd1, 16'h0000, "port_in_1edge");
    tick(); rd(3'd1, 16'hFFFF, "port_in_2edge"); rd(3'd5, 16'h0000, "pend_2edge");
    tick(); rd(3'd5, 16'h00FE, "pend_release_edge");
    tick(3); rd(3'd5, 16'h00FE, "pend_held");
    wr(3'd5, 16'h00FF); rd(3'd5, 16'h0000, "pend_cleared");
    pin_in = 16'h0000;
    tick(4); rd(3'd5, 16'h0000, "pend_fall_none");

    foreach (vecs[i]) begin
      wr(vecs[i].off, vecs[i].wdata);
      rd(vecs[i].off, vecs[i].rexp, vecs[i].name);
      chk({vecs[i].name, "_pin_out"}, pin_out, vecs[i].pout);
    end

    // a bus value driven by the bench must survive when the address misses
    drv = 16'h0000; drv_en = 1'b1; cpu_oe = 1'b0;
    addr = BASE + 16'd8; #1; chk("nohit_base8", datos, 16'h0000);
    addr = BASE ^ 16'h8000; #1; chk("nohit_upper", datos, 16'h0000);
    drv_en = 1'b0; addr = 16'h0000;

    // pin edge interrupt
    tick();
    wr(3'd6, 16'h0004);
    pin_in[1] = 1'b1;
    tick(); chk("pin_intr_e1", 16'(intr), 16'h0000);
    tick(); chk("pin_intr_e2", 16'(intr), 16'h0000); rd(3'd1, 16'h0002, "pin_port_in");
    tick(); chk("pin_intr_e3", 16'(intr), 16'h0004);
    wr(3'd5, 16'h0004); chk("pin_w1c", 16'(intr), 16'h0000);
    tick(4); chk("pin_no_retrig", 16'(intr), 16'h0000); rd(3'd5, 16'h0000, "pin_pend_clear");
    pin_in[2] = 1'b1;
    tick(2);
    wr(3'd5, 16'h0008); rd(3'd5, 16'h0008, "set_beats_w1c");
    wr(3'd5, 16'h0008); rd(3'd5, 16'h0000, "set_then_clear");

`ifdef IO_PERIPH_TIMER_EN
    // autoreload, period RELOAD+1
    wr(3'd6, 16'h0001); wr(3'd2, 16'd4); wr(3'd4, 16'h0003);
    tick(3); chk("tmr_e4", 16'(intr), 16'h0000); rd(3'd3, 16'd1, "count_dec");
    tick(); chk("tmr_e5", 16'(intr), 16'h0000);
    tick(); chk("tmr_expire1", 16'(intr), 16'h0001); rd(3'd3, 16'd4, "count_reload");
    wr(3'd5, 16'h0001); chk("tmr_w1c", 16'(intr), 16'h0000);
    tick(3); chk("tmr_e10", 16'(intr), 16'h0000);
    tick(); chk("tmr_period5", 16'(intr), 16'h0001);
    wr(3'd5, 16'h0001); tick(3);
    wr(3'd5, 16'h0001); chk("w1c_vs_expire", 16'(intr), 16'h0001);
    wr(3'd4, 16'h0000); wr(3'd5, 16'h0001);
    chk("tmr_stopped", 16'(intr), 16'h0000); rd(3'd4, 16'h0000, "ctrl_off");
    // one-shot
    wr(3'd2, 16'd2); wr(3'd4, 16'h0001);
    tick(2); chk("oneshot_f3", 16'(intr), 16'h0000);
    tick(); chk("oneshot_fire", 16'(intr), 16'h0001);
    rd(3'd4, 16'h0000, "oneshot_ctrl"); rd(3'd3, 16'h0000, "oneshot_count");
    tick(4); rd(3'd3, 16'h0000, "oneshot_count_hold");
    wr(3'd5, 16'h0001);
    tick(6); chk("oneshot_once", 16'(intr), 16'h0000);
    // RELOAD write while running: load, no decrement
    wr(3'd2, 16'd10); wr(3'd4, 16'h0001); tick();
    wr(3'd2, 16'd7); rd(3'd3, 16'd7, "reload_no_dec");
    wr(3'd4, 16'h0000); rd(3'd3, 16'd6, "count_after_stop");
    // RELOAD=0 autoreload fires every cycle
    wr(3'd2, 16'd0); wr(3'd4, 16'h0003);
    tick(); chk("reload0_fire", 16'(intr), 16'h0001);
    wr(3'd5, 16'h0001); chk("reload0_every", 16'(intr), 16'h0001);
    wr(3'd4, 16'h0000); wr(3'd5, 16'h0001); chk("reload0_stop", 16'(intr), 16'h0000);
    // CTRL write in the expiry cycle
    wr(3'd2, 16'd2); wr(3'd4, 16'h0001); tick(2);
    wr(3'd4, 16'h0003);
    rd(3'd4, 16'h0003, "ctrl_write_wins"); chk("ctrl_write_pend", 16'(intr), 16'h0001);
    wr(3'd4, 16'h0000); wr(3'd5, 16'h0001); chk("ctrl_cleanup", 16'(intr), 16'h0000);
    // reset mid-count with COUNT=3, PEND=81
    wr(3'd6, 16'h00FF);
    pin_in[6] = 1'b1;
    wr(3'd2, 16'd3); wr(3'd4, 16'h0003);
    tick(4); chk("pre_rst_intr", 16'(intr), 16'h0081); rd(3'd3, 16'd3, "pre_rst_count");
`else
    wr(3'd6, 16'h00FF);
    pin_in[6] = 1'b1;
    tick(3); chk("pre_rst_intr", 16'(intr), 16'h0080); rd(3'd5, 16'h0080, "pre_rst_pend");
`endif
    #1 reset = 1'b0;
    #1;
    chk("midrst_intr", 16'(intr), 16'h0000);
    chk("midrst_pin_out", pin_out, 16'h0000);
    reset = 1'b1;
    rd(3'd0, 16'h0000, "midrst_port");
    rd(3'd3, 16'h0000, "midrst_count");
    rd(3'd5, 16'h0000, "midrst_pend");
    tick();
    rd(3'd2, 16'h0000, "midrst_reload");
    rd(3'd4, 16'h0000, "midrst_ctrl");
    rd(3'd6, 16'h0000, "midrst_mask");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
